// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
//   Bundles the two requester handshakes and the SRAM pin-side signals of
//   sram_arbiter.
//   Requester port N (N = 0 recorder, 1 player):
//     i_reqN   level request, held until o_ackN is seen
//     i_weN    1 = write, 0 = read
//     i_addrN  word address
//     i_wdataN write data
//     o_ackN   single-cycle done pulse
//     o_rdataN read data, valid from the read ack onwards
//   SRAM side:
//     o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_OE, i_SRAM_DQ
//     o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N
//     o_busy   arbiter not idle
//   Modports: slave = arbiter view, master = requester / pin environment view.
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 16
) ();
  logic          i_req0;
  logic          i_we0;
  logic [AW-1:0] i_addr0;
  logic [DW-1:0] i_wdata0;
  logic          o_ack0;
  logic [DW-1:0] o_rdata0;

  logic          i_req1;
  logic          i_we1;
  logic [AW-1:0] i_addr1;
  logic [DW-1:0] i_wdata1;
  logic          o_ack1;
  logic [DW-1:0] o_rdata1;

  logic [AW-1:0] o_SRAM_ADDR;
  logic [DW-1:0] o_SRAM_DQ;
  logic          o_SRAM_DQ_OE;
  logic [DW-1:0] i_SRAM_DQ;
  logic          o_SRAM_CE_N;
  logic          o_SRAM_OE_N;
  logic          o_SRAM_WE_N;
  logic          o_SRAM_LB_N;
  logic          o_SRAM_UB_N;
  logic          o_busy;

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wdata0,
    input  i_req1, i_we1, i_addr1, i_wdata1,
    input  i_SRAM_DQ,
    output o_ack0, o_rdata0, o_ack1, o_rdata1,
    output o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_OE,
    output o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N,
    output o_busy
  );

  modport master (
    output i_req0, i_we0, i_addr0, i_wdata0,
    output i_req1, i_we1, i_addr1, i_wdata1,
    output i_SRAM_DQ,
    input  o_ack0, o_rdata0, o_ack1, o_rdata1,
    input  o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_OE,
    input  o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N,
    input  o_busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Shares one asynchronous 1M x 16 SRAM between a recorder (port 0) and a
//   player (port 1). Accesses are serialised as IDLE -> ACCESS -> TURN, the
//   strobes are held for ACCESS_CYCLES cycles, and each access ends with a
//   one-cycle ack during the bus-turnaround cycle. Every output is a flop.
//
//   Ports:
//     i_clk  system clock (rising edge)
//     i_rst  synchronous active-high reset
//     bus    sram_arbiter_if.slave (requester handshakes + SRAM pins)
//
//   Parameters: ACCESS_CYCLES (1..15), AW, DW.
//
//   Build option: define SRAM_ARB_ROUND_ROBIN_EN to replace the fixed
//   port-0-first priority with a 1-bit alternating priority pointer.
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW            = 20,
  parameter int DW            = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sram_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_TURN   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          sel_q, sel_d;        // port being served
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          ce_n_q, ce_n_d;      // also drives LB_N / UB_N
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          dq_oe_q, dq_oe_d;
  logic          busy_q, busy_d;

  logic          grant_sel;           // winner if a grant happens this cycle
  logic          access_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic          ptr_q, ptr_d;        // port preferred on a tie

  // A lone request wins outright; the pointer only breaks ties.
  assign grant_sel = (bus.i_req0 && bus.i_req1) ? ptr_q : ~bus.i_req0;
`else
  assign grant_sel = ~bus.i_req0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.i_req0 || bus.i_req1) begin
          // Address/data registers only load here, keeping the bus
          // stable for the whole access.
          sel_d   = grant_sel;
          we_d    = grant_sel ? bus.i_we1    : bus.i_we0;
          addr_d  = grant_sel ? bus.i_addr1  : bus.i_addr0;
          wdata_d = grant_sel ? bus.i_wdata1 : bus.i_wdata0;
          cnt_d   = CNT_LOAD;
          state_d = S_ACCESS;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          ptr_d   = ~grant_sel;
`endif
        end
      end

      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_TURN;
          if (!we_q) begin
            if (sel_q) rdata1_d = bus.i_SRAM_DQ;
            else       rdata0_d = bus.i_SRAM_DQ;
          end
          if (sel_q) ack1_d = 1'b1;
          else       ack0_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_TURN: begin
        // Strobes released, bus undriven; requests are not looked at.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up exactly
    // with the cycles spent in S_ACCESS.
    access_d = (state_d == S_ACCESS);
    ce_n_d   = ~access_d;
    oe_n_d   = ~(access_d && !we_d);
    we_n_d   = ~(access_d && we_d);
    dq_oe_d  = access_d && we_d;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
      busy_q   <= busy_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign bus.o_ack0       = ack0_q;
  assign bus.o_ack1       = ack1_q;
  assign bus.o_rdata0     = rdata0_q;
  assign bus.o_rdata1     = rdata1_q;
  assign bus.o_SRAM_ADDR  = addr_q;
  assign bus.o_SRAM_DQ    = wdata_q;
  assign bus.o_SRAM_DQ_OE = dq_oe_q;
  assign bus.o_SRAM_CE_N  = ce_n_q;
  assign bus.o_SRAM_LB_N  = ce_n_q;
  assign bus.o_SRAM_UB_N  = ce_n_q;
  assign bus.o_SRAM_OE_N  = oe_n_q;
  assign bus.o_SRAM_WE_N  = we_n_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Two arbiter instances: dut0 with ACCESS_CYCLES=2, dut1 with
//   ACCESS_CYCLES=1. A timestamp-based reference model predicts every
//   registered output each cycle; directed tests add literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Requester-side drive, indexed [dut][port]
  logic          req_s   [2][2];
  logic          we_s    [2][2];
  logic [AW-1:0] addr_s  [2][2];
  logic [DW-1:0] wdata_s [2][2];
  logic [DW-1:0] dq_in   [2];

  // Observed DUT outputs
  wire          ack_o   [2][2];
  wire [DW-1:0] rdata_o [2][2];
  wire [AW-1:0] sa_o    [2];
  wire [DW-1:0] sdq_o   [2];
  wire          dqoe_o  [2];
  wire          ce_n_o  [2];
  wire          oe_n_o  [2];
  wire          we_n_o  [2];
  wire          lb_n_o  [2];
  wire          ub_n_o  [2];
  wire          busy_o  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
      sram_arbiter #(.ACCESS_CYCLES(gi == 0 ? 2 : 1), .AW(AW), .DW(DW)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
      );
      assign bus.i_req0    = req_s[gi][0];
      assign bus.i_we0     = we_s[gi][0];
      assign bus.i_addr0   = addr_s[gi][0];
      assign bus.i_wdata0  = wdata_s[gi][0];
      assign bus.i_req1    = req_s[gi][1];
      assign bus.i_we1     = we_s[gi][1];
      assign bus.i_addr1   = addr_s[gi][1];
      assign bus.i_wdata1  = wdata_s[gi][1];
      assign bus.i_SRAM_DQ = dq_in[gi];
      assign ack_o[gi][0]   = bus.o_ack0;
      assign ack_o[gi][1]   = bus.o_ack1;
      assign rdata_o[gi][0] = bus.o_rdata0;
      assign rdata_o[gi][1] = bus.o_rdata1;
      assign sa_o[gi]   = bus.o_SRAM_ADDR;
      assign sdq_o[gi]  = bus.o_SRAM_DQ;
      assign dqoe_o[gi] = bus.o_SRAM_DQ_OE;
      assign ce_n_o[gi] = bus.o_SRAM_CE_N;
      assign oe_n_o[gi] = bus.o_SRAM_OE_N;
      assign we_n_o[gi] = bus.o_SRAM_WE_N;
      assign lb_n_o[gi] = bus.o_SRAM_LB_N;
      assign ub_n_o[gi] = bus.o_SRAM_UB_N;
      assign busy_o[gi] = bus.o_busy;
    end
  endgenerate

  int checks = 0;
  int errors = 0;
  int cyc = 0;                       // number of rising edges seen

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // ---------------- SRAM contents: pin environment and model image -------
  logic [DW-1:0] env_mem [int];
  logic [DW-1:0] mdl_mem [int];

  function automatic int key(input int d, input logic [AW-1:0] a);
    return d * (1 << AW) + int'(a);
  endfunction

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [DW-1:0] env_rd(input int d, input logic [AW-1:0] a);
    if (env_mem.exists(key(d, a))) return env_mem[key(d, a)];
    return dflt(a);
  endfunction

  function automatic logic [DW-1:0] mdl_rd(input int d, input logic [AW-1:0] a);
    if (mdl_mem.exists(key(d, a))) return mdl_mem[key(d, a)];
    return dflt(a);
  endfunction

  // SRAM pins: store while write strobes are active, return data while the
  // read strobes are active.
  initial begin
    dq_in[0] = '0;
    dq_in[1] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!ce_n_o[d] && !we_n_o[d]) env_mem[key(d, sa_o[d])] = sdq_o[d];
        dq_in[d] = (!ce_n_o[d] && !oe_n_o[d]) ? env_rd(d, sa_o[d]) : '0;
      end
    end
  end

  // ---------------- Reference model ----------------------------------
  // A grant at edge t0 means strobes on after edges t0..t0+AC-1, ack after
  // edge t0+AC, and the next grant no earlier than edge t0+AC+2.
  bit            mvalid [2];
  bit            mact   [2];
  int            mt0    [2];
  int            mfree  [2];
  bit            mw     [2];
  bit            mwe    [2];
  logic [AW-1:0] maddr  [2];
  logic [DW-1:0] mwd    [2];
  logic [DW-1:0] mrd    [2][2];
  bit            mptr   [2];
  bit            e_on   [2];
  bit            e_ack  [2][2];
  bit            e_busy [2];

  initial begin
    int ac;
    bit win;
    for (int d = 0; d < 2; d++) begin
      mvalid[d] = 0; mact[d] = 0; mfree[d] = 0; mt0[d] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        ac = (d == 0) ? 2 : 1;
        if (rst) begin
          mvalid[d] = 1; mact[d] = 0; mfree[d] = cyc + 1; mptr[d] = 0;
          mrd[d][0] = '0; mrd[d][1] = '0;
        end else if (mvalid[d]) begin
          if (mact[d] && cyc == mt0[d] + ac) begin
            if (mwe[d]) mdl_mem[key(d, maddr[d])] = mwd[d];
            else        mrd[d][mw[d]] = mdl_rd(d, maddr[d]);
          end
          if (cyc >= mfree[d] && (req_s[d][0] || req_s[d][1])) begin
            if (req_s[d][0] && req_s[d][1]) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
              win = mptr[d];
`else
              win = 1'b0;
`endif
            end else begin
              win = req_s[d][1];
            end
            mptr[d]  = ~win;
            mw[d]    = win;
            mwe[d]   = we_s[d][win];
            maddr[d] = addr_s[d][win];
            mwd[d]   = wdata_s[d][win];
            mact[d]  = 1;
            mt0[d]   = cyc;
            mfree[d] = cyc + ac + 2;
          end
        end
        e_on[d]     = mact[d] && cyc >= mt0[d] && cyc <= mt0[d] + ac - 1;
        e_ack[d][0] = mact[d] && cyc == mt0[d] + ac && !mw[d];
        e_ack[d][1] = mact[d] && cyc == mt0[d] + ac && mw[d];
        e_busy[d]   = mact[d] && cyc <= mt0[d] + ac;
      end
    end
  end

  // ---------------- Per-cycle compare -----------------------------------
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mvalid[d]) begin
          chk("ce_n",   d, ce_n_o[d], !e_on[d]);
          chk("lb_n",   d, lb_n_o[d], !e_on[d]);
          chk("ub_n",   d, ub_n_o[d], !e_on[d]);
          chk("oe_n",   d, oe_n_o[d], !(e_on[d] && !mwe[d]));
          chk("we_n",   d, we_n_o[d], !(e_on[d] && mwe[d]));
          chk("dq_oe",  d, dqoe_o[d], e_on[d] && mwe[d]);
          chk("busy",   d, busy_o[d], e_busy[d]);
          chk("ack0",   d, ack_o[d][0], e_ack[d][0]);
          chk("ack1",   d, ack_o[d][1], e_ack[d][1]);
          chk("rdata0", d, rdata_o[d][0], mrd[d][0]);
          chk("rdata1", d, rdata_o[d][1], mrd[d][1]);
          if (e_on[d]) chk("addr", d, sa_o[d], maddr[d]);
          if (e_on[d] && mwe[d]) chk("dq", d, sdq_o[d], mwd[d]);
          chk("oe_we_overlap",  d, !oe_n_o[d] && !we_n_o[d], 0);
          chk("drive_on_read",  d, dqoe_o[d] && !oe_n_o[d], 0);
        end
      end
    end
  end

  // ---------------- Requester task --------------------------------------
  // Called on a falling edge; raises req, waits for the ack, drops req.
  task automatic access(input int d, input int p, input bit we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output int ack_at);
    int n;
    req_s[d][p] = 1'b1; we_s[d][p] = we; addr_s[d][p] = a; wdata_s[d][p] = wd;
    n = 0;
    ack_at = -1;
    while (ack_at < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (ack_o[d][p]) ack_at = cyc;
    end
    req_s[d][p] = 1'b0;
    if (ack_at < 0) chk("ack_timeout", d, ack_o[d][p], 1);
    else $display("dut%0d port%0d %s addr=%05h data=%04h ack@%0d", d, p,
                  we ? "WR" : "RD", a, we ? wd : rdata_o[d][p], ack_at);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int order_q[$];

  // ---------------- Directed stimulus -----------------------------------
  initial begin
    int t, a0, a1, prev, ta, tb;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req_s[d][p] = 0; we_s[d][p] = 0; addr_s[d][p] = '0; wdata_s[d][p] = '0;
      end
    env_mem[key(0, 20'h00010)] = 16'hBEEF;
    mdl_mem[key(0, 20'h00010)] = 16'hBEEF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy",   0, busy_o[0], 0);
    chk("rst_ce_n",   0, ce_n_o[0], 1);
    chk("rst_dq_oe",  0, dqoe_o[0], 0);
    chk("rst_addr",   0, sa_o[0], 0);
    chk("rst_rdata1", 0, rdata_o[0][1], 0);

    // Single read, port 1
    t = cyc;
    access(0, 1, 1'b0, 20'h00010, 16'h0000, a1);
    chk("rd_latency",     0, a1 - t, 3);
    chk("rd_data",        0, rdata_o[0][1], 16'hBEEF);
    chk("rd_rdata0_kept", 0, rdata_o[0][0], 16'h0000);

    // Single write to the top address, port 0, then read it back
    access(0, 0, 1'b1, 20'hFFFFF, 16'h1234, a0);
    chk("wr_mem",         0, env_rd(0, 20'hFFFFF), 16'h1234);
    chk("wr_rdata0_kept", 0, rdata_o[0][0], 16'h0000);
    access(0, 1, 1'b0, 20'hFFFFF, 16'h0000, a1);
    chk("wr_readback",    0, rdata_o[0][1], 16'h1234);

    // Simultaneous requests after reset: port 0 first, port 1 four cycles on
    do_reset();
    fork
      access(0, 0, 1'b1, 20'h00100, 16'hAAAA, ta);
      access(0, 1, 1'b0, 20'h00200, 16'h0000, tb);
    join
    chk("tie_port0_first", 0, ta < tb, 1);
    chk("tie_gap",         0, tb - ta, 4);
    chk("tie_rd_data",     0, rdata_o[0][1], 16'hA7A5);

    // Both requesters busy for 8 accesses
    do_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          access(0, 0, 1'b1, 20'h00300 + 20'(i), 16'h5000 + 16'(i), ta);
          order_q.push_back(0);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          access(0, 1, 1'b0, 20'h00400 + 20'(j), 16'h0000, tb);
          order_q.push_back(1);
        end
      end
    join
    chk("order_len", 0, order_q.size(), 8);
    for (int i = 0; i < 8 && i < order_q.size(); i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      chk("rr_order", 0, order_q[i], i % 2);
`else
      chk("fixed_order", 0, order_q[i], (i < 4) ? 0 : 1);
`endif
    end

    // Reset during the first access cycle of a write
    repeat (2) @(negedge clk);
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 20'h00500; wdata_s[0][0] = 16'h7777;
    @(negedge clk);
    chk("rst_mid_pre_we_n", 0, we_n_o[0], 0);
    rst = 1'b1;
    req_s[0][0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ce_n",   0, ce_n_o[0], 1);
    chk("rst_mid_we_n",   0, we_n_o[0], 1);
    chk("rst_mid_dq_oe",  0, dqoe_o[0], 0);
    chk("rst_mid_ack0",   0, ack_o[0][0], 0);
    chk("rst_mid_busy",   0, busy_o[0], 0);
    chk("rst_mid_rdata1", 0, rdata_o[0][1], 16'h0000);

    // Back-to-back reads on the single-cycle-access instance
    @(negedge clk);
    t = cyc;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      access(1, 1, 1'b0, 20'h00600 + 20'(i), 16'h0000, a1);
      if (i == 0) chk("b2b_first_latency", 1, a1 - t, 2);
      else        chk("b2b_gap", 1, a1 - prev, 3);
      prev = a1;
    end
    chk("b2b_last_data", 1, rdata_o[1][1], 16'hA3A6);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single off-chip 1M x 16 SRAM between two requesters: port 0 (recorder, normally writes) and port 1 (player, normally reads).
- Sits between those two blocks and the SRAM pins in the audio top level, on the system clock.
- Serialises their accesses, generates the active-low SRAM strobes, and returns read data with a one-cycle acknowledge.

Parameters:
- ACCESS_CYCLES, 2: cycles the strobes are held active per access. Legal range 1..15.
- AW, 20: SRAM address width.
- DW, 16: SRAM data width.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req0  in  1  port 0 request (level)
- i_we0  in  1  port 0: 1 = write, 0 = read
- i_addr0  in  AW  port 0 address
- i_wdata0  in  DW  port 0 write data
- o_ack0  out  1  port 0 done pulse
- o_rdata0  out  DW  port 0 read data
- i_req1, i_we1, i_addr1, i_wdata1, o_ack1, o_rdata1: same as the port 0 signals, for port 1
- o_SRAM_ADDR  out  AW  SRAM address
- o_SRAM_DQ  out  DW  SRAM write data
- o_SRAM_DQ_OE  out  1  1 = drive DQ pins (top level tri-states)
- i_SRAM_DQ  in  DW  SRAM read data
- o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  active-low strobes
- o_busy  out  1  state != S_IDLE

Behaviour:
- Reset and outputs:
  - All outputs are registered.
  - On reset: state S_IDLE, all strobes 1, o_SRAM_DQ_OE 0, addr/DQ 0, acks 0, rdata 0, o_busy 0, priority pointer at port 0.
  - Reset asserted in any state takes effect at the next edge. Any in-flight access is abandoned and no ack is issued.
- Request protocol:
  - A requester holds req, we, addr and wdata stable until it sees ack = 1.
  - It drops req on the edge at which it samples ack.
  - Ack is a single-cycle pulse.
  - o_rdataN updates on the same edge that raises o_ackN for a read, and holds until that port's next read ack.
  - Write acks leave rdata unchanged.
- State machine: S_IDLE -> S_ACCESS -> S_TURN -> S_IDLE.
  - **S_IDLE:** if any req is high, pick a winner and latch its we/addr/wdata. Load counter = ACCESS_CYCLES-1 and go to S_ACCESS. With no req, stay in S_IDLE.
  - **S_ACCESS:** CE_N=0, LB_N=UB_N=0, o_SRAM_ADDR = latched addr.
    - Write: WE_N=0, OE_N=1, DQ_OE=1, DQ = latched wdata.
    - Read: OE_N=0, WE_N=1, DQ_OE=0.
    - Counter decrements each cycle. When counter==0: a read captures i_SRAM_DQ into the winner's rdata, the winner's ack is set, and the state moves to S_TURN.
  - **S_TURN:** the winner's ack is high, all strobes are 1 and DQ_OE is 0 (bus turnaround). Requests are ignored. Go to S_IDLE.
- Latency and throughput:
  - If req is sampled in S_IDLE at edge k, strobes are active during cycles k+1..k+ACCESS_CYCLES.
  - Ack is high in cycle k+ACCESS_CYCLES+1.
  - Peak throughput is one access per ACCESS_CYCLES+2 cycles.
- Arbitration (baseline): fixed priority, port 0 wins ties. Port 1 is served only when req0 is low in S_IDLE.
- Boundary conditions:
  - req dropped mid-access: the access still completes and ack still pulses.
  - Address 0xFFFFF is a valid address (no wrap logic).
  - Both reqs high with one already granted: the loser waits. Its request is evaluated again in the next S_IDLE.
  - Write data and address registers change only in S_IDLE on grant, so the bus is stable across S_ACCESS.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit priority pointer.
  - On a tie in S_IDLE, the port not granted last wins.
  - After each grant the pointer moves to the other port. Reset value is "port 0 preferred".
  - A lone request is granted regardless of the pointer.
- Not defined: fixed priority, port 0 highest. No pointer register exists.

Test Plan:
- **Single read:** ACCESS_CYCLES=2; port 1 reads 0x00010, SRAM model returns 0xBEEF.
  - OE_N=0 and CE_N=0 for exactly 2 cycles, WE_N=1, DQ_OE=0.
  - o_ack1 pulses 3 cycles after the grant edge, o_rdata1=0xBEEF, o_rdata0 unchanged.
- **Single write:** port 0 writes addr 0xFFFFF, data 0x1234.
  - WE_N=0 and DQ_OE=1 for 2 cycles with DQ=0x1234.
  - o_ack0 pulses once and the model holds 0x1234 at 0xFFFFF.
- **Simultaneous requests, fixed priority:** both reqs raised on the same cycle.
  - Port 0 acked first; port 1 acked exactly 4 cycles later.
  - With both held continuously (requester re-raises req the cycle after ack), port 1 is never granted.
- **Simultaneous requests, SRAM_ARB_ROUND_ROBIN_EN defined:** both reqs held continuously for 8 accesses.
  - Grants alternate 0,1,0,1..., 4 acks per port.
- **Reset mid-access:** assert i_rst during the 1st S_ACCESS cycle of a write.
  - Next cycle: all strobes 1, DQ_OE 0, no ack, o_busy 0, rdata 0.
- **Back-to-back reads:** ACCESS_CYCLES=1, port 1 issues 4 reads.
  - One ack every 3 cycles.
  - No cycle has OE_N=0 and WE_N=0 together, and no cycle has DQ_OE=1 with OE_N=0.
